// File: rtl/mem_responder.sv
// mem_responder: two-player record store (public keys + net money) with a
// fixed-latency request/response handshake.
//
// Ports:
//   clock, reset              : single clock, asynchronous active-high reset
//   start                     : request strobe, sampled only while idle
//   protocol[2:0]             : requester tag, echoed on protocol_out
//   access_p2                 : 0 = player 1 record, 1 = player 2 record
//   access_type[1:0]          : 01 = public key, 10 = net money, 00/11 invalid
//   wren, data_in[7:0]        : write enable and write data
//   busy                      : request in flight (ACCESS/WAIT/RESPOND)
//   done                      : one-cycle completion pulse, 3 edges after accept
//   data_out[7:0], error,
//   protocol_out[2:0]         : response, valid with done, held afterwards
//
// Latency: start sampled at edge N, done high in the cycle after edge N+3.
// Backpressure: none; start outside IDLE is dropped, throughput one request
// per 4 cycles.

module mem_responder #(
  parameter logic [7:0] INIT_MONEY = 8'd100,
  parameter logic [7:0] KEY_P1     = 8'h3A,
  parameter logic [7:0] KEY_P2     = 8'hC5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] protocol,
  input  logic       access_p2,
  input  logic [1:0] access_type,
  input  logic       wren,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic [2:0] protocol_out,
  output logic       error
);

  localparam logic [1:0] TYPE_KEY   = 2'b01;
  localparam logic [1:0] TYPE_MONEY = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Captured request fields
  logic [2:0] req_protocol;
  logic       req_p2;
  logic [1:0] req_type;
  logic       req_wren;
  logic [7:0] req_data;

  // Storage
  logic [7:0] p1_key;
  logic [7:0] p2_key;
  logic [7:0] p1_money;
  logic [7:0] p2_money;

  // Result computed in ACCESS, published when leaving RESPOND
  logic [7:0] result_dat;
  logic       result_err;

  // Combinational helpers
  logic       accept;
  logic       leave_respond;
  logic       req_invalid;
  logic       money_write;
  logic [7:0] sel_value;

  // ---------------------------------------------------------------------------
  // FSM: fixed walk through ACCESS -> WAIT -> RESPOND once a request is taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    leave_respond = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = WAIT;
      WAIT:    next_state = RESPOND;
      RESPOND: begin
        leave_respond = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // busy follows the state directly so an asynchronous reset drops it at once.
  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    req_invalid = 1'b1;
    money_write = 1'b0;
    sel_value   = 8'h00;
    case (req_type)
      TYPE_KEY: begin
        // Keys are read-only: a write attempt is rejected outright.
        req_invalid = req_wren;
        sel_value   = req_p2 ? p2_key : p1_key;
      end
      TYPE_MONEY: begin
        req_invalid = 1'b0;
        money_write = req_wren && (state == ACCESS);
        sel_value   = req_p2 ? p2_money : p1_money;
      end
      default: begin
        req_invalid = 1'b1;
        sel_value   = 8'h00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture (only on acceptance, so start while busy has no effect)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_protocol <= 3'b000;
      req_p2       <= 1'b0;
      req_type     <= 2'b00;
      req_wren     <= 1'b0;
      req_data     <= 8'h00;
    end else if (accept) begin
      req_protocol <= protocol;
      req_p2       <= access_p2;
      req_type     <= access_type;
      req_wren     <= wren;
      req_data     <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Keys are loaded only by reset and otherwise never change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p1_key <= KEY_P1;
      p2_key <= KEY_P2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p1_money <= INIT_MONEY;
      p2_money <= INIT_MONEY;
    end else if (money_write) begin
      if (req_p2) begin
        p2_money <= req_data;
      end else begin
        p1_money <= req_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result: sampled in ACCESS. A write reads back the value being written,
  // since the register itself only updates on this same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_dat <= 8'h00;
      result_err <= 1'b0;
    end else if (state == ACCESS) begin
      result_err <= req_invalid;
      if (req_invalid) begin
        result_dat <= 8'h00;
      end else if (money_write) begin
        result_dat <= req_data;
      end else begin
        result_dat <= sel_value;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response outputs. error clears on the next accepted start; data_out and
  // protocol_out hold until the next completion overwrites them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done         <= 1'b0;
      data_out     <= 8'h00;
      protocol_out <= 3'b000;
      error        <= 1'b0;
    end else begin
      done <= leave_respond;
      if (leave_respond) begin
        data_out     <= result_dat;
        protocol_out <= req_protocol;
        error        <= result_err;
      end else if (accept) begin
        error <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter INIT_MONEY, default 8'd100, reset value of both players' net-money registers.
REQ-002 SHALL have parameter KEY_P1, default 8'h3A, read-only public key of player 1.
REQ-003 SHALL have parameter KEY_P2, default 8'hC5, read-only public key of player 2.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request strobe, sampled only in IDLE.
REQ-007 SHALL have port protocol  input  3  requester protocol tag, echoed back.
REQ-008 SHALL have port access_p2  input  1  0 = player 1 record, 1 = player 2 record.
REQ-009 SHALL have port access_type  input  2  01 = public key, 10 = net money; 00/11 invalid.
REQ-010 SHALL have port wren  input  1  1 = write data_in, 0 = read.
REQ-011 SHALL have port data_in  input  8  write data.
REQ-012 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port data_out  output  8  result, valid while done=1, held until next accepted start.
REQ-015 SHALL have port protocol_out  output  3  captured protocol tag, valid with done.
REQ-016 SHALL have port error  output  1  request rejected, valid with done.

Function
REQ-017 SHALL hold four 8-bit registers: p1_key, p2_key, p1_money, p2_money.
REQ-018 SHALL implement FSM states IDLE, ACCESS, WAIT, RESPOND, cycling IDLE->ACCESS->WAIT->RESPOND->IDLE unconditionally after acceptance.
REQ-019 SHALL accept start only in IDLE, capturing protocol, access_p2, access_type, wren, data_in in that cycle; start in any other state is ignored with no effect.
REQ-020 SHALL assert done exactly 3 cycles after the accepting edge (start sampled at edge N -> done high during cycle after edge N+3), for one cycle.
REQ-021 SHALL assert busy in ACCESS, WAIT and RESPOND states; busy=0 in IDLE.
REQ-022 SHALL, in ACCESS with wren=1 and access_type=10, write captured data_in into the selected player's money register.
REQ-023 SHALL treat public keys as read-only: wren=1 with access_type=01 performs no write and sets error=1.
REQ-024 SHALL, for access_type 00 or 11, perform no read or write, set error=1, data_out=8'h00.
REQ-025 SHALL, for valid reads, drive data_out with the selected register value as of the ACCESS cycle.
REQ-026 SHALL, for valid money writes, drive data_out with the newly written value (read-back).
REQ-027 SHALL, on error, leave all storage registers unchanged and drive data_out=8'h00.
REQ-028 SHALL drive protocol_out with the captured protocol tag for every completed request, valid or not.
REQ-029 SHALL clear error at the next accepted start; error and data_out otherwise hold.
REQ-030 SHALL allow start in the cycle after done (back-to-back requests, 4-cycle throughput).

Reset
REQ-031 SHALL, on reset assertion, immediately (asynchronously) force state=IDLE, busy=0, done=0, error=0, data_out=8'h00, protocol_out=3'b000.
REQ-032 SHALL, on reset, load p1_money=p2_money=INIT_MONEY, p1_key=KEY_P1, p2_key=KEY_P2.
REQ-033 SHALL abandon any in-flight request on reset mid-operation: no done pulse; a write reaching ACCESS before reset is overwritten by reset values.
REQ-034 SHALL ignore start while reset is high.

Verification
REQ-035 Reset then start, protocol=001, access_p2=0, access_type=10, wren=0 -> done 3 cycles later, data_out=8'd100, protocol_out=001, error=0.
REQ-036 Start access_p2=1, access_type=01, wren=0, protocol=110 -> data_out=8'hC5, protocol_out=110, error=0.
REQ-037 Write access_p2=1, access_type=10, wren=1, data_in=8'd42, then read same -> both return data_out=8'd42; p1 money still reads 8'd100.
REQ-038 Write access_type=01, data_in=8'hFF -> error=1, data_out=8'h00; subsequent key read returns KEY_P1/KEY_P2 unchanged; access_type=11 -> error=1.
REQ-039 Pulse start during busy -> ignored, single done; start the cycle after done -> accepted, done 3 cycles later.
REQ-040 Assert reset during WAIT of a money write of 8'd7 -> no done, busy=0 immediately, following read returns 8'd100.
